// File: rtl/apb_master_bridge.sv
// APB initiator: turns a valid/ready command/response port into APB SETUP/ACCESS transfers.
// Optional watchdog on ACCESS wait states is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic                      cmd_write,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pwrite_d  = cmd_write;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
`ifdef APB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            StAccess: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    state_d     = StResp;
`ifdef APB_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CntLast) begin
                    // Last tolerated wait cycle just ended with pready still low: abort.
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= StIdle;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed cases plus random transfers against a
// cycle-schedule reference model; the bench also plays the APB slave.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
`ifdef APB_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          presetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr, paddr;
    logic [DW-1:0] cmd_wdata, pwdata, prdata, rsp_rdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic          pwrite, psel, penable, pready, pslverr;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transfer, entered and left at a negedge with the bridge idle. Cycle k is the k-th
    // cycle after the one presenting the command: psel from k=1, penable from k=2, response
    // at k=3+nwait, or at k=2+TO when the watchdog is built in and the slave stalls too long.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                        input int nwait, input logic [DW-1:0] rd, input logic err,
                        input int hold);
        bit            to;
        int            kdone;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        logic [3:0]    exp_ctl;
        bit            last;

        to      = ToEn && (nwait >= TO);
        kdone   = to ? 2 + TO : 3 + nwait;
        exp_rd  = (to || wr) ? '0 : rd;
        exp_err = to ? 1'b1 : err;

        check_eq("idle_ready", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_wdata = wd;
        pready    = 1'b0;
        for (int k = 1; k <= kdone; k++) begin
            @(negedge pclk);
            cmd_valid = 1'b0;
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            cmd_write = 1'($urandom);
            exp_ctl   = {1'(k < kdone), 1'(k >= 2 && k < kdone), 1'(k == kdone), 1'b0};
            check_eq("ctl_psel_pen_rv_rdy", {60'd0, psel, penable, rsp_valid, cmd_ready},
                     {60'd0, exp_ctl});
            if (k < kdone) begin
                check_eq("paddr", {32'd0, paddr}, {32'd0, addr});
                check_eq("pwrite_pwdata", {31'd0, pwrite, pwdata}, {31'd0, wr, wd});
            end
            last    = !to && (k == 2 + nwait);
            pready  = last;
            pslverr = last ? err : 1'b1;
            prdata  = last ? rd : DW'($urandom);
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        check_eq("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rd});
        check_eq("rsp_err_to", {62'd0, rsp_err, rsp_timeout}, {62'd0, exp_err, to});
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge pclk);
            check_eq("rsp_hold", {27'd0, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel,
                     cmd_ready}, {27'd0, 1'b1, exp_rd, exp_err, to, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check_eq("rsp_done", {61'd0, rsp_valid, cmd_ready, psel}, {61'd0, 3'b010});
        check_eq("paddr_held", {32'd0, paddr}, {32'd0, addr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #1;
        check_eq("reset_outs", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable,
                 pwrite}, 39'd0);
        check_eq("reset_bus", {paddr, pwdata}, 64'd0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        check_eq("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

        xfer(32'h1000, 1'b1, 32'hA5A5_A5A5, 0, 32'h1234_5678, 1'b0, 0);
        xfer(32'h2004, 1'b0, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 0);
        xfer(32'h3008, 1'b0, 32'h0, 0, 32'h5555_AAAA, 1'b1, 1);
        xfer(32'h300C, 1'b0, 32'h0, 3, 32'h0BAD_BEEF, 1'b0, 0);
        xfer(32'h4000, 1'b1, 32'h0F0F_0F0F, 1, 32'h0, 1'b0, 5);
        xfer(32'h4004, 1'b0, 32'h0, TO - 1, 32'h7777_0001, 1'b0, 0);
        xfer(32'h5000, 1'b0, 32'h0, TO + 24, 32'h8888_0002, 1'b0, 1);

        // Reset in the middle of ACCESS must drop the transfer without a response.
        cmd_valid = 1'b1;
        cmd_addr  = 32'h6000;
        cmd_write = 1'b1;
        cmd_wdata = 32'hDEAD_0001;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check_eq("pre_reset_access", {62'd0, psel, penable}, 64'd3);
        presetn = 1'b0;
        #1;
        check_eq("async_reset", {31'd0, psel, penable, rsp_valid, paddr}, 64'd0);
        pready = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        pready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check_eq("post_reset_idle", {61'd0, rsp_valid, psel, cmd_ready}, 64'd1);
        end

        for (int t = 0; t < 40; t++) begin
            xfer(AW'($urandom), 1'($urandom), DW'($urandom), int'($urandom_range(0, 4)),
                 DW'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
